// File: rtl/fu_cluster_if.sv
// Issue / writeback bundle for fu_cluster: per-lane signals are packed lane-major
// (lane i occupies bits [i*W +: W] of each vector).
interface fu_cluster_if #(
  parameter int SS        = 2,
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 3,
  parameter int PREG_W    = 6
);
  logic                    flush;
  logic [SS-1:0]           issue_valid;
  logic [SS-1:0]           issue_ready;
  logic [SS*2-1:0]         issue_class;
  logic [SS*3-1:0]         issue_alu_op;
  logic [SS*3-1:0]         issue_cmp_op;
  logic [SS*2-1:0]         issue_mul_type;
  logic [SS-1:0]           issue_op1_pc;
  logic [SS-1:0]           issue_op2_imm;
  logic [SS*XLEN-1:0]      issue_rs1;
  logic [SS*XLEN-1:0]      issue_rs2;
  logic [SS*XLEN-1:0]      issue_pc;
  logic [SS*XLEN-1:0]      issue_imm;
  logic [SS*ROB_IDX_W-1:0] issue_rob;
  logic [SS*PREG_W-1:0]    issue_pd;
  logic [SS-1:0]           wb_valid;
  logic [SS-1:0]           wb_ready;
  logic [SS*XLEN-1:0]      wb_value;
  logic [SS*ROB_IDX_W-1:0] wb_rob;
  logic [SS*PREG_W-1:0]    wb_pd;
  logic [SS-1:0]           lane_busy;

  modport master (
    output flush, issue_valid, issue_class, issue_alu_op, issue_cmp_op, issue_mul_type,
           issue_op1_pc, issue_op2_imm, issue_rs1, issue_rs2, issue_pc, issue_imm,
           issue_rob, issue_pd, wb_ready,
    input  issue_ready, wb_valid, wb_value, wb_rob, wb_pd, lane_busy
  );

  modport slave (
    input  flush, issue_valid, issue_class, issue_alu_op, issue_cmp_op, issue_mul_type,
           issue_op1_pc, issue_op2_imm, issue_rs1, issue_rs2, issue_pc, issue_imm,
           issue_rob, issue_pd, wb_ready,
    output issue_ready, wb_valid, wb_value, wb_rob, wb_pd, lane_busy
  );
endinterface

// File: rtl/fu_cluster.sv
// SS-lane execute cluster: single-cycle ALU/CMP plus iterative radix-2^(XLEN/MUL_CYCLES) multiplier.
// Optional: define FU_CLUSTER_MUL_EARLY_OUT_EN to end a multiply once the remaining multiplier bits are zero.
module fu_cluster #(
  parameter int SS         = 2,
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4,
  parameter int ROB_IDX_W  = 3,
  parameter int PREG_W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  fu_cluster_if.slave  bus
);

  localparam int CHUNK = XLEN / MUL_CYCLES;
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [1:0] CLS_CMP = 2'd1;
  localparam logic [1:0] CLS_MUL = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
                         ALU_XOR = 3'd4, ALU_SLL = 3'd5, ALU_SRL = 3'd6, ALU_SRA = 3'd7;
  localparam logic [2:0] CMP_BEQ = 3'd0, CMP_BNE = 3'd1, CMP_BLT  = 3'd4,
                         CMP_BGE = 3'd5, CMP_BLTU = 3'd6, CMP_BGEU = 3'd7;
  localparam logic [1:0] MT_MUL = 2'd0, MT_MULH = 2'd1, MT_MULHU = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

  for (genvar i = 0; i < SS; i++) begin : g_lane
    logic [1:0]           cls, mul_type;
    logic [2:0]           alu_op, cmp_op;
    logic [XLEN-1:0]      rs1, rs2, op_a, op_b;
    logic [ROB_IDX_W-1:0] rob;
    logic [PREG_W-1:0]    pd;

    assign cls      = bus.issue_class[i*2 +: 2];
    assign mul_type = bus.issue_mul_type[i*2 +: 2];
    assign alu_op   = bus.issue_alu_op[i*3 +: 3];
    assign cmp_op   = bus.issue_cmp_op[i*3 +: 3];
    assign rs1      = bus.issue_rs1[i*XLEN +: XLEN];
    assign rs2      = bus.issue_rs2[i*XLEN +: XLEN];
    assign op_a     = bus.issue_op1_pc[i]  ? bus.issue_pc[i*XLEN +: XLEN]  : rs1;
    assign op_b     = bus.issue_op2_imm[i] ? bus.issue_imm[i*XLEN +: XLEN] : rs2;
    assign rob      = bus.issue_rob[i*ROB_IDX_W +: ROB_IDX_W];
    assign pd       = bus.issue_pd[i*PREG_W +: PREG_W];

    state_e               state_q, state_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]      wb_value_q, wb_value_d;
    logic [ROB_IDX_W-1:0] wb_rob_q, wb_rob_d;
    logic [PREG_W-1:0]    wb_pd_q, wb_pd_d;
    logic [2*XLEN-1:0]    mcand_q, mcand_d, acc_q, acc_d;
    logic [XLEN-1:0]      mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [1:0]           mtype_q, mtype_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 issue_ready, accept, cmp_res, a_neg, b_neg, mul_done;
    logic [XLEN-1:0]      alu_res, mag_a, mag_b, mplier_rest, mul_res;
    logic [2*XLEN-1:0]    acc_next, prod;

    assign issue_ready = !rst && !bus.flush &&
                         ((state_q == S_IDLE && !wb_valid_q) ||
                          (state_q == S_HOLD && bus.wb_ready[i]) ||
                          (state_q == S_IDLE && wb_valid_q && bus.wb_ready[i]));
    assign accept = bus.issue_valid[i] && issue_ready;

    always_comb begin
      case (alu_op)
        ALU_ADD: alu_res = op_a + op_b;
        ALU_SUB: alu_res = op_a - op_b;
        ALU_AND: alu_res = op_a & op_b;
        ALU_OR:  alu_res = op_a | op_b;
        ALU_XOR: alu_res = op_a ^ op_b;
        ALU_SLL: alu_res = op_a << op_b[SH_W-1:0];
        ALU_SRL: alu_res = op_a >> op_b[SH_W-1:0];
        default: alu_res = $unsigned($signed(op_a) >>> op_b[SH_W-1:0]);
      endcase
    end

    // Compares always see the register sources, never pc/imm.
    always_comb begin
      case (cmp_op)
        CMP_BEQ:  cmp_res = (rs1 == rs2);
        CMP_BNE:  cmp_res = (rs1 != rs2);
        CMP_BLT:  cmp_res = ($signed(rs1) <  $signed(rs2));
        CMP_BGE:  cmp_res = ($signed(rs1) >= $signed(rs2));
        CMP_BLTU: cmp_res = (rs1 <  rs2);
        CMP_BGEU: cmp_res = (rs1 >= rs2);
        default:  cmp_res = 1'b0;
      endcase
    end

    // Multiply magnitudes unsigned and restore the sign at the end, so the
    // multiplier operand is non-negative and early-out needs no sign case.
    assign a_neg = (mul_type != MT_MULHU) && op_a[XLEN-1];
    assign b_neg = (mul_type == MT_MUL || mul_type == MT_MULH) && op_b[XLEN-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

    assign acc_next    = acc_q + mcand_q * {{(2*XLEN-CHUNK){1'b0}}, mplier_q[CHUNK-1:0]};
    assign mplier_rest = mplier_q >> CHUNK;
    assign prod        = neg_q ? -acc_next : acc_next;
    assign mul_res     = (mtype_q == MT_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef FU_CLUSTER_MUL_EARLY_OUT_EN
    assign mul_done    = (cnt_q == CNT_LAST) || (mplier_rest == '0);
`else
    assign mul_done    = (cnt_q == CNT_LAST);
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      state_d    = state_q;
      wb_valid_d = wb_valid_q && !bus.wb_ready[i];
      wb_value_d = wb_value_q;
      wb_rob_d   = wb_rob_q;
      wb_pd_d    = wb_pd_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      neg_d      = neg_q;
      mtype_d    = mtype_q;
      cnt_d      = cnt_q;

      if (state_q == S_MUL) begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << CHUNK;
        mplier_d = mplier_rest;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_done) begin
          wb_valid_d = 1'b1;
          wb_value_d = mul_res;
          state_d    = bus.wb_ready[i] ? S_IDLE : S_HOLD;
          cnt_d      = '0;
        end
      end else begin
        if (state_q == S_HOLD && bus.wb_ready[i]) state_d = S_IDLE;
        if (accept) begin
          wb_rob_d = rob;
          wb_pd_d  = pd;
          if (cls == CLS_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, mag_a};
            mplier_d = mag_b;
            neg_d    = a_neg ^ b_neg;
            mtype_d  = mul_type;
            cnt_d    = '0;
          end else begin
            wb_valid_d = 1'b1;
            wb_value_d = (cls == CLS_CMP) ? {{(XLEN-1){1'b0}}, cmp_res} : alu_res;
            state_d    = bus.wb_ready[i] ? S_IDLE : S_HOLD;
          end
        end
      end

      // Flush outranks both issue and completion.
      if (bus.flush) begin
        state_d    = S_IDLE;
        wb_valid_d = 1'b0;
        cnt_d      = '0;
      end
    end

    // NOTE: the datapath registers are few and feed visible outputs, so all are reset
    // to give deterministic wb_* values; sequential state uses non-blocking assignment only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= S_IDLE;
        wb_valid_q <= 1'b0;
        wb_value_q <= '0;
        wb_rob_q   <= '0;
        wb_pd_q    <= '0;
        mcand_q    <= '0;
        mplier_q   <= '0;
        acc_q      <= '0;
        neg_q      <= 1'b0;
        mtype_q    <= '0;
        cnt_q      <= '0;
      end else begin
        state_q    <= state_d;
        wb_valid_q <= wb_valid_d;
        wb_value_q <= wb_value_d;
        wb_rob_q   <= wb_rob_d;
        wb_pd_q    <= wb_pd_d;
        mcand_q    <= mcand_d;
        mplier_q   <= mplier_d;
        acc_q      <= acc_d;
        neg_q      <= neg_d;
        mtype_q    <= mtype_d;
        cnt_q      <= cnt_d;
      end
    end

    assign bus.issue_ready[i]                     = issue_ready;
    assign bus.wb_valid[i]                        = wb_valid_q;
    assign bus.wb_value[i*XLEN +: XLEN]           = wb_value_q;
    assign bus.wb_rob[i*ROB_IDX_W +: ROB_IDX_W]   = wb_rob_q;
    assign bus.wb_pd[i*PREG_W +: PREG_W]          = wb_pd_q;
    assign bus.lane_busy[i]                       = (state_q == S_MUL);
  end

endmodule

// File: tb/tb_fu_cluster.sv
// Directed bench for fu_cluster (default build, SS=2, XLEN=32, MUL_CYCLES=4).
module tb_fu_cluster;
  localparam int SS = 2, XLEN = 32, MUL_CYCLES = 4, ROB_IDX_W = 3, PREG_W = 6;

  localparam logic [1:0] C_ALU = 2'd0, C_CMP = 2'd1, C_MUL = 2'd2;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1;
  localparam logic [2:0] K_BLT = 3'd4, K_BLTU = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0, n_fail = 0, n_total = 0;

  fu_cluster_if #(.SS(SS), .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)) bus ();

  fu_cluster #(.SS(SS), .XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES), .ROB_IDX_W(ROB_IDX_W),
               .PREG_W(PREG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int ln, input logic [1:0] cls, input logic [2:0] aop,
                       input logic [2:0] cop, input logic [1:0] mt, input logic use_pc,
                       input logic use_imm, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pcv, input logic [31:0] immv,
                       input logic [2:0] rob, input logic [5:0] pd);
    bus.issue_valid[ln]           = 1'b1;
    bus.issue_class[ln*2 +: 2]    = cls;
    bus.issue_alu_op[ln*3 +: 3]   = aop;
    bus.issue_cmp_op[ln*3 +: 3]   = cop;
    bus.issue_mul_type[ln*2 +: 2] = mt;
    bus.issue_op1_pc[ln]          = use_pc;
    bus.issue_op2_imm[ln]         = use_imm;
    bus.issue_rs1[ln*32 +: 32]    = r1;
    bus.issue_rs2[ln*32 +: 32]    = r2;
    bus.issue_pc[ln*32 +: 32]     = pcv;
    bus.issue_imm[ln*32 +: 32]    = immv;
    bus.issue_rob[ln*3 +: 3]      = rob;
    bus.issue_pd[ln*6 +: 6]       = pd;
  endtask

  task automatic add(input int ln, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [2:0] rob, input logic [5:0] pd);
    drive(ln, C_ALU, A_ADD, 3'd0, 2'd0, 1'b0, 1'b0, r1, r2, 32'd0, 32'd0, rob, pd);
  endtask

  function automatic logic [31:0] val(input int ln);
    return bus.wb_value[ln*32 +: 32];
  endfunction

  function automatic logic [2:0] robo(input int ln);
    return bus.wb_rob[ln*3 +: 3];
  endfunction

  function automatic logic [5:0] pdo(input int ln);
    return bus.wb_pd[ln*6 +: 6];
  endfunction

  logic [31:0] mul_exp [5];
  logic [1:0]  mul_typ [5];
  logic [31:0] mul_a   [5];
  logic [31:0] mul_b   [5];

  initial begin
    mul_typ[0] = 2'd0; mul_a[0] = 32'h8000_0000; mul_b[0] = 32'hFFFF_FFFF; mul_exp[0] = 32'h8000_0000;
    mul_typ[1] = 2'd1; mul_a[1] = 32'h8000_0000; mul_b[1] = 32'hFFFF_FFFF; mul_exp[1] = 32'h0000_0000;
    mul_typ[2] = 2'd2; mul_a[2] = 32'h8000_0000; mul_b[2] = 32'hFFFF_FFFF; mul_exp[2] = 32'h8000_0000;
    mul_typ[3] = 2'd3; mul_a[3] = 32'h8000_0000; mul_b[3] = 32'hFFFF_FFFF; mul_exp[3] = 32'h7FFF_FFFF;
    mul_typ[4] = 2'd0; mul_a[4] = 32'd7;         mul_b[4] = 32'hFFFF_FFFD; mul_exp[4] = 32'hFFFF_FFEB;

    bus.flush = 1'b0;          bus.issue_valid = '0;    bus.issue_class = '0;
    bus.issue_alu_op = '0;     bus.issue_cmp_op = '0;   bus.issue_mul_type = '0;
    bus.issue_op1_pc = '0;     bus.issue_op2_imm = '0;  bus.issue_rs1 = '0;
    bus.issue_rs2 = '0;        bus.issue_pc = '0;       bus.issue_imm = '0;
    bus.issue_rob = '0;        bus.issue_pd = '0;       bus.wb_ready = '0;

    // Reset state
    repeat (2) tick();
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_lane_busy", 64'(bus.lane_busy), 64'd0);
    check("rst_wb_value", bus.wb_value, 64'd0);
    check("rst_wb_tags", 64'({bus.wb_rob, bus.wb_pd}), 64'd0);
    add(0, 32'd1, 32'd1, 3'd0, 6'd0);
    #1 check("rst_issue_ready", 64'(bus.issue_ready), 64'd0);
    bus.issue_valid = '0;
    rst = 1'b0;
    bus.wb_ready = 2'b11;
    tick();

    // Lane 0 ADD and back-to-back throughput
    add(0, 32'd5, 32'd7, 3'd3, 6'd9);
    #1 check("add_ready", 64'(bus.issue_ready[0]), 64'd1);
    tick();
    check("add_valid", 64'(bus.wb_valid[0]), 64'd1);
    check("add_value", 64'(val(0)), 64'd12);
    check("add_rob", 64'(robo(0)), 64'd3);
    check("add_pd", 64'(pdo(0)), 64'd9);
    for (int k = 0; k < 4; k++) begin
      add(0, 32'(100 + k), 32'(k), 3'(k), 6'(k + 20));
      tick();
      check("b2b_valid", 64'(bus.wb_valid[0]), 64'd1);
      check("b2b_value", 64'(val(0)), 64'(100 + 2 * k));
      check("b2b_pd", 64'(pdo(0)), 64'(k + 20));
    end
    drive(0, C_ALU, A_SUB, 3'd0, 2'd0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 3'd1, 6'd1);
    tick();
    check("sub_value", 64'(val(0)), 64'hFFFF_FFFE);
    drive(0, C_ALU, A_ADD, 3'd0, 2'd0, 1'b1, 1'b1, 32'h55, 32'h66, 32'h100, 32'h4, 3'd2, 6'd2);
    tick();
    check("pc_imm_value", 64'(val(0)), 64'h104);
    bus.issue_valid[0] = 1'b0;
    tick();
    check("drain_valid", 64'(bus.wb_valid[0]), 64'd0);

    // Lane 1 compares ignore the pc/imm selects
    drive(1, C_CMP, 3'd0, K_BLT, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h80, 3'd5, 6'd33);
    tick();
    check("blt_valid", 64'(bus.wb_valid[1]), 64'd1);
    check("blt_value", 64'(val(1)), 64'd1);
    check("blt_pd", 64'(pdo(1)), 64'd33);
    drive(1, C_CMP, 3'd0, K_BLTU, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h80, 3'd6, 6'd34);
    tick();
    check("bltu_value", 64'(val(1)), 64'd0);
    bus.issue_valid[1] = 1'b0;
    tick();

    // Multiplier type matrix, result at N+5
    for (int t = 0; t < 5; t++) begin
      drive(0, C_MUL, 3'd0, 3'd0, mul_typ[t], 1'b0, 1'b0, mul_a[t], mul_b[t], 32'd0, 32'd0,
            3'(t), 6'(40 + t));
      #1 check("mul_ready", 64'(bus.issue_ready[0]), 64'd1);
      tick();
      bus.issue_valid[0] = 1'b0;
      check("mul_busy", 64'(bus.lane_busy[0]), 64'd1);
      check("mul_busy_ready", 64'(bus.issue_ready[0]), 64'd0);
      for (int c = 0; c < 3; c++) begin
        tick();
        check("mul_not_yet", 64'(bus.wb_valid[0]), 64'd0);
      end
      tick();
      check("mul_valid", 64'(bus.wb_valid[0]), 64'd1);
      check("mul_value", 64'(val(0)), 64'(mul_exp[t]));
      check("mul_rob", 64'(robo(0)), 64'(t));
      check("mul_busy_drop", 64'(bus.lane_busy[0]), 64'd0);
    end
    tick();
    check("mul_drain", 64'(bus.wb_valid[0]), 64'd0);

    // Backpressure: hold three cycles, then transfer and issue in the same cycle
    bus.wb_ready[0] = 1'b0;
    add(0, 32'd1, 32'd2, 3'd1, 6'd2);
    tick();
    check("bp_valid", 64'(bus.wb_valid[0]), 64'd1);
    add(0, 32'd10, 32'd20, 3'd6, 6'd7);
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_ready_low", 64'(bus.issue_ready[0]), 64'd0);
      check("bp_hold_value", 64'(val(0)), 64'd3);
      check("bp_hold_rob", 64'(robo(0)), 64'd1);
      check("bp_hold_valid", 64'(bus.wb_valid[0]), 64'd1);
      tick();
    end
    bus.wb_ready[0] = 1'b1;
    #1 check("bp_ready_high", 64'(bus.issue_ready[0]), 64'd1);
    tick();
    check("bp_next_valid", 64'(bus.wb_valid[0]), 64'd1);
    check("bp_next_value", 64'(val(0)), 64'd30);
    check("bp_next_rob", 64'(robo(0)), 64'd6);
    bus.issue_valid[0] = 1'b0;
    tick();
    check("bp_drain", 64'(bus.wb_valid[0]), 64'd0);

    // Flush during MUL on lane 0 with a held result on lane 1
    bus.wb_ready = 2'b01;
    add(1, 32'h11, 32'h22, 3'd2, 6'd12);
    drive(0, C_MUL, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd0, 3'd4, 6'd20);
    tick();
    bus.issue_valid = '0;
    check("fl_busy", 64'(bus.lane_busy[0]), 64'd1);
    check("fl_held", 64'(val(1)), 64'h33);
    tick();
    bus.flush = 1'b1;
    bus.wb_ready[1] = 1'b1;
    add(1, 32'd1, 32'd1, 3'd7, 6'd1);
    #1 check("fl_ready", 64'(bus.issue_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.issue_valid = '0;
    check("fl_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("fl_lane_busy", 64'(bus.lane_busy), 64'd0);
    add(0, 32'd2, 32'd2, 3'd1, 6'd3);
    #1 check("fl_recover_ready", 64'(bus.issue_ready[0]), 64'd1);
    tick();
    check("fl_recover_value", 64'(val(0)), 64'd4);
    bus.issue_valid = '0;
    tick();

    // Asynchronous reset in the middle of a multiply
    drive(0, C_MUL, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 3'd1, 6'd1);
    tick();
    bus.issue_valid[0] = 1'b0;
    tick();
    check("rm_busy_before", 64'(bus.lane_busy[0]), 64'd1);
    rst = 1'b1;
    #1 check("rm_busy_async", 64'(bus.lane_busy), 64'd0);
    check("rm_valid_async", 64'(bus.wb_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    add(0, 32'd8, 32'd9, 3'd5, 6'd5);
    #1 check("rm_ready", 64'(bus.issue_ready[0]), 64'd1);
    tick();
    check("rm_value", 64'(val(0)), 64'd17);
    check("rm_not_mul", 64'(bus.lane_busy[0]), 64'd0);
    bus.issue_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fu_cluster.md
Name: fu_cluster

Overview:
- Parametrised successor to the per-lane execute stage. Provides SS independent lanes, each with a single-cycle ALU/CMP path and an iterative multi-cycle multiplier.
- Each lane has a valid/ready issue handshake from the reservation station and a registered, back-pressurable writeback port toward the CDB/ROB.
- A global flush squashes all in-flight work.

Parameters:
- SS, 2, number of lanes.
- XLEN, 32, operand/result width (power of 2).
- MUL_CYCLES, 4, multiplier iterations; XLEN/MUL_CYCLES bits retired per cycle; must divide XLEN.
- ROB_IDX_W, 3, ROB tag width.
- PREG_W, 6, physical destination register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  squash all lanes.
- issue_valid  in  SS  per-lane op offered.
- issue_ready  out  SS  per-lane op accepted this cycle.
- issue_class  in  SS*2  0=ALU, 1=CMP, 2=MUL, 3=reserved (treated as ALU).
- issue_alu_op  in  SS*3  ALU function, codebase encoding.
- issue_cmp_op  in  SS*3  compare function, codebase encoding.
- issue_mul_type  in  SS*2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- issue_op1_pc  in  SS  operand A = pc instead of rs1.
- issue_op2_imm  in  SS  operand B = imm instead of rs2.
- issue_rs1, issue_rs2, issue_pc, issue_imm  in  SS*XLEN each  source values.
- issue_rob  in  SS*ROB_IDX_W  ROB tag.
- issue_pd  in  SS*PREG_W  destination physical register.
- wb_valid  out  SS  result held.
- wb_ready  in  SS  consumer takes result.
- wb_value  out  SS*XLEN  result.
- wb_rob  out  SS*ROB_IDX_W  tag of the result.
- wb_pd  out  SS*PREG_W  destination of the result.
- lane_busy  out  SS  multiplier iterating.

Behaviour:
- Reset and flush:
  - Async reset: all lanes IDLE; wb_valid=0; lane_busy=0; wb_value/wb_rob/wb_pd=0; iteration counters=0.
  - issue_ready is combinational; it is 0 during reset.
- Per-lane FSM states: IDLE, MUL, HOLD.
- issue_ready[i]:
  - = (state==IDLE && !wb_valid[i]) || (state==HOLD && wb_ready[i]) || (state==IDLE && wb_valid[i] && wb_ready[i]).
  - Forced to 0 while flush=1.
- Operand selection:
  - A = op1_pc ? pc : rs1.
  - B = op2_imm ? imm : rs2.
  - CMP always compares rs1 vs rs2, regardless of the select bits.
- ALU/CMP op accepted in cycle N:
  - wb_valid=1 at N+1, with value, rob and pd registered.
  - CMP result is zero-extended 1 bit.
  - Lane stays IDLE if wb_ready was high when the result is produced; otherwise it goes to HOLD.
  - Back-to-back issue is allowed with wb_ready=1, giving 1 result/cycle.
- MUL op accepted in cycle N:
  - Enter MUL; lane_busy=1; latch operands, tag and type.
  - Signedness: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned. Computed as 2·XLEN-bit product via sign-extended operands.
  - One radix chunk per cycle; after MUL_CYCLES cycles, wb_valid=1 at N+MUL_CYCLES+1.
  - Result: MUL = product[XLEN-1:0]; others = product[2XLEN-1:XLEN].
  - lane_busy drops in the same cycle wb_valid rises.
- HOLD:
  - wb_* outputs stable while wb_valid && !wb_ready.
  - Transfer occurs on wb_valid && wb_ready.
  - New issue is accepted in the same cycle as the transfer: no bubble.
- Flush:
  - Applies at the next edge: all lanes go to IDLE; wb_valid=0; multiplier abandoned.
  - Flush beats issue and completion in the same cycle; the op presented alongside flush is not accepted.
- Lanes are fully independent; there is no cross-lane arbitration.
- Results appear in per-lane completion order; lanes may complete out of order relative to each other.

Optional Feature:
- Macro: FU_CLUSTER_MUL_EARLY_OUT_EN.
- With the macro defined: a MUL finishes after the first iteration in which the remaining unshifted multiplier-operand bits are all zero (unsigned view after sign handling). Minimum latency is 1 iteration; results are bit-identical to the full run.
- Without the macro: latency is always exactly MUL_CYCLES iterations.

Test Plan:
- Reset mid-MUL: reset asserted at iteration 2 -> wb_valid=0, lane_busy=0 immediately (async); lane accepts a new op 1 cycle after release.
- Lane 0, ALU ADD, rs1=5, rs2=7, wb_ready=1 -> next cycle wb_value=12, wb_rob/wb_pd match; 4 back-to-back ADDs -> 4 consecutive wb_valid cycles.
- Lane 1, CMP BLT, rs1=0xFFFFFFFF, rs2=1, op1_pc=1, op2_imm=1 -> wb_value=1 (rs operands used).
- MUL type matrix: 0x80000000 × 0xFFFFFFFF:
  - MUL -> 0x80000000.
  - MULH -> 0x00000000.
  - MULHSU -> 0x80000000.
  - MULHU -> 0x7FFFFFFF.
  - Each result appears at N+5 with MUL_CYCLES=4 (early-out off).
- Backpressure: wb_ready=0 for 3 cycles after an ALU result -> outputs stable, issue_ready=0; on wb_ready=1, the transfer and a new issue occur in the same cycle.
- Flush during MUL on lane 0 with a held result on lane 1 -> both wb_valid=0 next cycle; a flush-cycle issue is rejected (issue_ready=0).
